alu_issue_queue: RTL and testbench

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_cmd_fifo_mem.sv | 26 ++
 rtl/alu_issue_queue.sv | 113 +++++++++++
 tb/tb_alu_issue_queue.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and field widths, used by the issue
// queue and by the ALU itself.
package alu_pkg;

  localparam int OPCODE_W = 4;
  localparam int SHAMT_W  = 5;

  localparam logic [OPCODE_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_AND   = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_OR    = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_SLL   = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_SGT   = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_PASSB = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_SLT   = 4'd7;

  function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
    return op <= OP_SLT;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo_mem.sv
// Command storage for the ALU issue queue: DEPTH x CMD_W register array with one
// write port and an asynchronous read address so the head falls through.
module alu_cmd_fifo_mem #(
  parameter int CMD_W = 73,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [CMD_W-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [CMD_W-1:0]         rd_data
);

  // Contents are never reset; validity is tracked by the controller's count.
  logic [CMD_W-1:0] entry_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      entry_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = entry_q[rd_addr];

endmodule

// File: rtl/alu_issue_queue.sv
// First-word-fall-through issue queue feeding {opcode, a, b, shamt} to the ALU.
// Optional macro ALU_ISSUE_OPCHECK_EN: drop opcodes > 7 and flag them on illegal_op.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPCODE_W-1:0]   in_opcode,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  input  logic [SHAMT_W-1:0]    in_shamt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OPCODE_W-1:0]   opcode,
  output logic [WIDTH-1:0]      input1,
  output logic [WIDTH-1:0]      input2,
  output logic [SHAMT_W-1:0]    shiftValue,
`ifdef ALU_ISSUE_OPCHECK_EN
  output logic                  illegal_op,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int CMD_W = OPCODE_W + 2 * WIDTH + SHAMT_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             hs_in, push, pop;
  logic [CMD_W-1:0] wr_data, rd_data;

  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign hs_in     = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef ALU_ISSUE_OPCHECK_EN
  logic illegal_op_q, illegal_op_d;

  assign push         = hs_in && op_is_legal(in_opcode);
  assign illegal_op_d = hs_in && !op_is_legal(in_opcode);
  assign illegal_op   = illegal_op_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_op_q <= 1'b0;
    else     illegal_op_q <= illegal_op_d;
  end
`else
  assign push = hs_in;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_data = {in_opcode, in_a, in_b, in_shamt};

  alu_cmd_fifo_mem #(
    .CMD_W (CMD_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // Stale array contents must never leak out while the queue is empty.
  always_comb begin
    opcode     = '0;
    input1     = '0;
    input2     = '0;
    shiftValue = '0;
    if (out_valid) begin
      {opcode, input1, input2, shiftValue} = rd_data;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: a tracker models occupancy and queues the
// expected head commands; a monitor checks the head every valid cycle.
module tb_alu_issue_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       sh;
  } cmd_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_opcode;
  logic [WIDTH-1:0] in_a, in_b;
  logic [4:0]       in_shamt;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] input1, input2;
  logic [4:0]       shiftValue;
  logic [2:0]       count;
`ifdef ALU_ISSUE_OPCHECK_EN
  logic             illegal_op;
`endif

  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_pops = 0;
  int   model_cnt = 0;
  cmd_t exp_q[$];

  alu_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_shamt   (in_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .opcode     (opcode),
    .input1     (input1),
    .input2     (input2),
    .shiftValue (shiftValue),
`ifdef ALU_ISSUE_OPCHECK_EN
    .illegal_op (illegal_op),
`endif
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [4:0] sh);
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_shamt  = sh;
  endtask

  task automatic push_one(input logic [3:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [4:0] sh);
    set_cmd(op, a, b, sh);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    out_ready = 1'b1;
    while (out_valid && guard < 20) begin
      tick();
      guard++;
    end
    out_ready = 1'b0;
    check("drain_empty", out_valid, 0);
  endtask

  // Tracker: occupancy model and expected-command queue, updated per handshake.
  always @(negedge clk) begin
    cmd_t c;
    bit   push_ok, pop_ok, legal;
    if (rst) begin
      model_cnt = 0;
      exp_q.delete();
      check("rst_count", count, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
    end else begin
      check("trk_count", count, model_cnt);
      check("trk_in_ready", in_ready, model_cnt < DEPTH);
      check("trk_out_valid", out_valid, model_cnt != 0);
      legal = 1'b1;
`ifdef ALU_ISSUE_OPCHECK_EN
      legal = (in_opcode <= 4'd7);
`endif
      push_ok = in_valid && (model_cnt < DEPTH) && legal;
      pop_ok  = out_ready && (model_cnt != 0);
      if (push_ok) begin
        c.op = in_opcode; c.a = in_a; c.b = in_b; c.sh = in_shamt;
        exp_q.push_back(c);
      end
      model_cnt = model_cnt + int'(push_ok) - int'(pop_ok);
    end
  end

  // Monitor: head must match the oldest expected command whenever presented.
  always @(negedge clk) begin
    cmd_t e;
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("mon_unexpected_valid", out_valid, 0);
        end else begin
          e = exp_q[0];
          check("mon_head", {opcode, input1, input2, shiftValue}, {e.op, e.a, e.b, e.sh});
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_pops++;
          end
        end
      end else begin
        check("mon_idle_zero", {opcode, input1, input2, shiftValue}, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int snap;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_cmd(4'd0, 0, 0, 5'd0);
    repeat (2) tick();
    check("reset_count", count, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_outputs", {opcode, input1, input2, shiftValue}, 0);
    rst = 1'b0;
    tick();

    // latency: ADD 5,7 visible one cycle after the push edge, not before
    set_cmd(4'd0, 32'd5, 32'd7, 5'd0);
    in_valid = 1'b1;
    check("lat_no_bypass", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("lat_valid", out_valid, 1);
    check("lat_opcode", opcode, 0);
    check("lat_input1", input1, 5);
    check("lat_input2", input2, 7);
    tick();
    check("lat_hold_input1", input1, 5);
    drain();

    // full: four AND commands fill the queue
    for (int k = 0; k < 4; k++) push_one(4'd2, k, k + 1, 5'(k));
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    set_cmd(4'd4, 32'd99, 32'd1, 5'd3);
    in_valid = 1'b1;
    tick();
    check("full_reject_count", count, 4);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("full_pop_count", count, 3);
    check("full_pop_in_ready", in_ready, 1);
    check("full_pop_head", input1, 1);
    drain();

    // simultaneous push and pop at count 2
    push_one(4'd3, 32'h10, 32'h20, 5'd1);
    push_one(4'd3, 32'h30, 32'h40, 5'd2);
    set_cmd(4'd3, 32'h50, 32'h60, 5'd3);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("sim_count", count, 2);
    check("sim_head_a", input1, 32'h30);
    check("sim_head_b", input2, 32'h40);
    drain();

    // order and wrap: SUB i,1 for i=0..9 with out_ready toggling
    snap = n_pops;
    i = 0;
    for (int cyc = 0; cyc < 100 && i < 10; cyc++) begin
      set_cmd(4'd1, i, 32'd1, 5'd0);
      in_valid  = 1'b1;
      out_ready = cyc[0];
      if (in_ready) begin
        tick();
        i++;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    check("wrap_sent", i, 10);
    drain();
    check("wrap_popped", n_pops - snap, 10);

    // mid-stream reset with three entries queued
    for (int k = 0; k < 3; k++) push_one(4'd5, 32'h100 + k, 32'h200, 5'd4);
    check("mid_count", count, 3);
    rst = 1'b1;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_outputs", {opcode, input1, input2, shiftValue}, 0);
    tick();
    rst = 1'b0;
    tick();
    push_one(4'd6, 32'd1, 32'hAB, 5'd7);
    check("post_rst_opcode", opcode, 6);
    check("post_rst_input2", input2, 32'hAB);
    check("post_rst_count", count, 1);
    drain();

    // opcodes above 7
`ifdef ALU_ISSUE_OPCHECK_EN
    check("illegal_idle", illegal_op, 0);
    push_one(4'd9, 32'd3, 32'd4, 5'd0);
    check("illegal_pulse", illegal_op, 1);
    check("illegal_count", count, 0);
    tick();
    check("illegal_clear", illegal_op, 0);
`else
    push_one(4'd12, 32'hDEAD, 32'hBEEF, 5'd31);
    check("op12_opcode", opcode, 12);
    check("op12_shift", shiftValue, 31);
    drain();
`endif
    push_one(4'd7, 32'd8, 32'd9, 5'd2);
    check("slt_count", count, 1);
    check("slt_opcode", opcode, 7);
    drain();

    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
